// File: rtl/mirfak_wbs_sram.sv
// Wishbone classic slave SRAM: one request at a time, WAIT_STATES extra cycles, registered ack/err.
// Optional error termination on miss/misalignment when MIRFAK_WBS_SRAM_ERR_EN is defined.
module mirfak_wbs_sram #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          MEM_AW      = 10,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wbs_addr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o
);

  localparam int DEPTH = 1 << MEM_AW;
  localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_WAIT = 3'b010,
    ST_RESP = 3'b100
  } state_t;

  state_t             state_r, state_s;
  logic [3:0]         cnt_r, cnt_s;
  logic [31:0]        addr_r, dat_r;
  logic [3:0]         sel_r;
  logic               we_r;
  logic               ack_r, err_r;
  logic [31:0]        rdat_r;
  logic [31:0]        mem_r [DEPTH];

  logic               req_s;
  logic               enter_resp_s;
  logic [31:0]        eff_addr_s, eff_dat_s;
  logic [3:0]         eff_sel_s;
  logic               eff_we_s;
  logic               hit_s, fault_s, ok_s, do_write_s;
  logic [MEM_AW-1:0]  idx_s;

  assign req_s = wbs_cyc_i & wbs_stb_i;

  // With zero wait states the edge entering RESP is the accept edge, so the live bus fields are used.
  assign eff_addr_s = (state_r == ST_IDLE) ? wbs_addr_i : addr_r;
  assign eff_dat_s  = (state_r == ST_IDLE) ? wbs_dat_i  : dat_r;
  assign eff_sel_s  = (state_r == ST_IDLE) ? wbs_sel_i  : sel_r;
  assign eff_we_s   = (state_r == ST_IDLE) ? wbs_we_i   : we_r;

  assign hit_s = (eff_addr_s[31:MEM_AW+2] == BASE_ADDR[31:MEM_AW+2]);
  assign idx_s = eff_addr_s[MEM_AW+1:2];

`ifdef MIRFAK_WBS_SRAM_ERR_EN
  assign fault_s = ~hit_s | (eff_addr_s[1:0] != 2'b00);
`else
  logic unused_addr_lsb_s;
  assign unused_addr_lsb_s = ^eff_addr_s[1:0];
  assign fault_s = 1'b0;
`endif

  assign ok_s         = hit_s & ~fault_s;
  assign enter_resp_s = (state_s == ST_RESP);
  assign do_write_s   = enter_resp_s & eff_we_s & ok_s & ~rst_i;

  // Next-state and wait-counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          cnt_s = WS_CNT;
          if (WS_CNT != 4'd0) begin
            state_s = ST_WAIT;
          end else begin
            state_s = ST_RESP;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!req_s) begin
          state_s = ST_IDLE;
          cnt_s   = 4'd0;
        end else if (cnt_r == 4'd1) begin
          state_s = ST_RESP;
          cnt_s   = 4'd0;
        end else begin
          state_s = ST_WAIT;
          cnt_s   = cnt_r - 4'd1;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // FSM state, request capture and registered response outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= 32'h0000_0000;
      dat_r   <= 32'h0000_0000;
      sel_r   <= 4'b0000;
      we_r    <= 1'b0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      rdat_r  <= 32'h0000_0000;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (state_r == ST_IDLE && req_s) begin
        addr_r <= wbs_addr_i;
        dat_r  <= wbs_dat_i;
        sel_r  <= wbs_sel_i;
        we_r   <= wbs_we_i;
      end
      ack_r <= enter_resp_s & ~fault_s;
      err_r <= enter_resp_s & fault_s;
      if (enter_resp_s) begin
        rdat_r <= ok_s ? mem_r[idx_s] : 32'h0000_0000;
      end
    end
  end

  // Byte-lane write into the array; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (do_write_s) begin
      for (int n = 0; n < 4; n++) begin
        if (eff_sel_s[n]) begin
          mem_r[idx_s][8*n +: 8] <= eff_dat_s[8*n +: 8];
        end
      end
    end
  end

  assign wbs_dat_o = rdat_r;
  assign wbs_ack_o = ack_r;
  assign wbs_err_o = err_r;

endmodule

// File: tb/tb_mirfak_wbs_sram.sv
// Randomized self-checking bench for mirfak_wbs_sram: two instances (0 and 3 wait states)
// compared against a word/byte-lane array model of the memory map.
module tb_mirfak_wbs_sram;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int WS0 = 0;
  localparam int WS1 = 3;

  logic              clk;
  logic [1:0]        rst;
  logic [1:0][31:0]  addr, wdat, rdat;
  logic [1:0][3:0]   sel;
  logic [1:0]        cyc, stb, we, ack, err;

  int checks;
  int failures;

  logic [31:0] mdl [2][1024];
  logic [3:0]  kn  [2][1024];

  mirfak_wbs_sram #(.BASE_ADDR(BASE), .MEM_AW(10), .WAIT_STATES(WS0)) u_dut0 (
    .clk_i(clk), .rst_i(rst[0]), .wbs_addr_i(addr[0]), .wbs_dat_i(wdat[0]),
    .wbs_sel_i(sel[0]), .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]), .wbs_we_i(we[0]),
    .wbs_dat_o(rdat[0]), .wbs_ack_o(ack[0]), .wbs_err_o(err[0])
  );

  mirfak_wbs_sram #(.BASE_ADDR(BASE), .MEM_AW(10), .WAIT_STATES(WS1)) u_dut1 (
    .clk_i(clk), .rst_i(rst[1]), .wbs_addr_i(addr[1]), .wbs_dat_i(wdat[1]),
    .wbs_sel_i(sel[1]), .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]), .wbs_we_i(we[1]),
    .wbs_dat_o(rdat[1]), .wbs_ack_o(ack[1]), .wbs_err_o(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] lane_mask(input logic [3:0] k);
    logic [31:0] m;
    for (int n = 0; n < 4; n++) m[8*n +: 8] = {8{k[n]}};
    return m;
  endfunction

  // One complete bus transaction on instance d with model update and checks.
  task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] s, output logic [31:0] rd);
    bit hit, ex_err;
    int idx, lat, c;
    bit done;
    logic [31:0] ex_dat, msk;
    hit = (a >= BASE) && (a < BASE + 32'h0000_1000);
    idx = int'((a - BASE) >> 2) & 1023;
    ex_err = 1'b0;
`ifdef MIRFAK_WBS_SRAM_ERR_EN
    ex_err = !hit || (a[1:0] != 2'b00);
`endif
    lat = (d == 0) ? WS0 + 1 : WS1 + 1;
    if (hit && !ex_err) begin
      ex_dat = mdl[d][idx];
      msk    = lane_mask(kn[d][idx]);
    end else begin
      ex_dat = 32'h0000_0000;
      msk    = 32'hFFFF_FFFF;
    end
    @(negedge clk);
    addr[d] = a; wdat[d] = wd; sel[d] = s; we[d] = w; cyc[d] = 1'b1; stb[d] = 1'b1;
    c = 0; done = 1'b0;
    while (!done && c < 40) begin
      @(posedge clk); #1;
      c++;
      if (ack[d] || err[d]) done = 1'b1;
    end
    rd = rdat[d];
    checks++;
    if (c !== lat) begin
      failures++;
      $display("FAIL latency dut%0d addr=%h: got %0d cycles, expected %0d", d, a, c, lat);
    end
    checks++;
    if ({ack[d], err[d]} !== (ex_err ? 2'b01 : 2'b10)) begin
      failures++;
      $display("FAIL term dut%0d addr=%h: ack/err=%b%b, expected %b", d, a, ack[d], err[d],
               ex_err ? 2'b01 : 2'b10);
    end
    if (!w) begin
      checks++;
      if ((rd & msk) !== (ex_dat & msk)) begin
        failures++;
        $display("FAIL rdata dut%0d addr=%h: got %h, expected %h (mask %h)", d, a, rd, ex_dat, msk);
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ack[d] !== 1'b0 || err[d] !== 1'b0) begin
      failures++;
      $display("FAIL pulse dut%0d addr=%h: ack/err=%b%b one cycle later, expected 00", d, a, ack[d], err[d]);
    end
    if (w && hit && !ex_err) begin
      for (int n = 0; n < 4; n++) begin
        if (s[n]) begin
          mdl[d][idx][8*n +: 8] = wd[8*n +: 8];
          kn[d][idx][n] = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 2'b11;
    cyc = 2'b00; stb = 2'b00; we = 2'b00;
    addr = '0; wdat = '0; sel = '0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ack[d] !== 1'b0 || err[d] !== 1'b0 || rdat[d] !== 32'h0000_0000) begin
        failures++;
        $display("FAIL reset dut%0d: ack=%b err=%b dat=%h, expected 0/0/0", d, ack[d], err[d], rdat[d]);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 2'b00;
  endtask

  task automatic test_basic_read();
    logic [31:0] rd;
    txn(0, 1'b1, BASE, 32'hDEAD_BEEF, 4'b1111, rd);
    txn(0, 1'b0, BASE, 32'h0000_0000, 4'b1111, rd);
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL basic_read: got %h, expected DEADBEEF", rd);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd;
    txn(1, 1'b1, BASE + 32'h20, 32'hC0FF_EE01, 4'b1111, rd);
    txn(1, 1'b0, BASE + 32'h20, 32'h0000_0000, 4'b1111, rd);
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd;
    for (int d = 0; d < 2; d++) begin
      txn(d, 1'b1, BASE + 32'h10, 32'hAABB_CCDD, 4'b1111, rd);
      txn(d, 1'b1, BASE + 32'h10, 32'h1122_3344, 4'b0101, rd);
      txn(d, 1'b1, BASE + 32'h10, 32'h5566_7788, 4'b0000, rd);
      txn(d, 1'b0, BASE + 32'h10, 32'h0000_0000, 4'b1111, rd);
      checks++;
      if (rd !== 32'hAA22_CC44) begin
        failures++;
        $display("FAIL byte_lanes dut%0d: got %h, expected AA22CC44", d, rd);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    int k, cyc_at[3];
    for (int i = 0; i < 3; i++) txn(0, 1'b1, BASE + 32'(4*i), $urandom, 4'b1111, rd);
    @(negedge clk);
    addr[0] = BASE; we[0] = 1'b0; sel[0] = 4'b1111; cyc[0] = 1'b1; stb[0] = 1'b1;
    k = 0;
    for (int t = 1; t <= 10 && k < 3; t++) begin
      @(posedge clk); #1;
      if (ack[0]) begin
        cyc_at[k] = t;
        checks++;
        if (rdat[0] !== mdl[0][k]) begin
          failures++;
          $display("FAIL b2b_data beat%0d: got %h, expected %h", k, rdat[0], mdl[0][k]);
        end
        k++;
        if (k < 3) addr[0] = BASE + 32'(4*k);
        else begin cyc[0] = 1'b0; stb[0] = 1'b0; end
      end
    end
    cyc[0] = 1'b0; stb[0] = 1'b0;
    checks++;
    if (k !== 3) begin
      failures++;
      $display("FAIL b2b_count: got %0d acks, expected 3", k);
    end
    for (int i = 0; i < k; i++) begin
      checks++;
      if (cyc_at[i] !== 2*i + 1) begin
        failures++;
        $display("FAIL b2b_cycle beat%0d: ack at cycle %0d, expected %0d", i, cyc_at[i], 2*i + 1);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (ack[0] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_tail: ack=%b after stream, expected 0", ack[0]);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    for (int d = 0; d < 2; d++) begin
      txn(d, 1'b0, BASE + 32'h0000_1000, 32'h0, 4'b1111, rd);
      checks++;
      if (rd !== 32'h0000_0000) begin
        failures++;
        $display("FAIL miss_data dut%0d: got %h, expected 0", d, rd);
      end
      txn(d, 1'b0, BASE + 32'h0000_0002, 32'h0, 4'b1111, rd);
      txn(d, 1'b1, BASE - 32'h0000_0004, 32'h1234_5678, 4'b1111, rd);
    end
  endtask

  task automatic test_abort_and_reset();
    logic [31:0] rd;
    int bad;
    txn(1, 1'b1, BASE + 32'h40, 32'h5A5A_1234, 4'b1111, rd);
    @(negedge clk);
    addr[1] = BASE + 32'h40; wdat[1] = 32'h0BAD_F00D; sel[1] = 4'b1111; we[1] = 1'b1;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    @(posedge clk); #1;
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    bad = 0;
    for (int t = 0; t < 6; t++) begin
      if (ack[1] || err[1]) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL abort_ack: %0d response cycles seen, expected 0", bad);
    end
    txn(1, 1'b0, BASE + 32'h40, 32'h0, 4'b1111, rd);
    checks++;
    if (rd !== 32'h5A5A_1234) begin
      failures++;
      $display("FAIL abort_mem: got %h, expected 5A5A1234", rd);
    end
    @(negedge clk);
    addr[1] = BASE + 32'h44; wdat[1] = 32'hFFFF_0000; sel[1] = 4'b1111; we[1] = 1'b1;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    @(posedge clk); #3;
    rst[1] = 1'b1;
    #1;
    checks++;
    if (ack[1] !== 1'b0 || err[1] !== 1'b0 || rdat[1] !== 32'h0000_0000) begin
      failures++;
      $display("FAIL async_reset: ack=%b err=%b dat=%h, expected 0/0/0", ack[1], err[1], rdat[1]);
    end
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    bad = 0;
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      if (ack[1] || err[1]) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL reset_drop: %0d response cycles after reset, expected 0", bad);
    end
    txn(1, 1'b0, BASE + 32'h40, 32'h0, 4'b1111, rd);
    checks++;
    if (rd !== 32'h5A5A_1234) begin
      failures++;
      $display("FAIL reset_retain: got %h, expected 5A5A1234", rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, a;
    int d, kind;
    for (int i = 0; i < 160; i++) begin
      d = int'($urandom_range(1, 0));
      kind = int'($urandom_range(9, 0));
      if (kind == 0) a = BASE + 32'h0000_1000 + 32'($urandom_range(255, 0) * 4);
      else if (kind == 1) a = BASE + 32'($urandom_range(63, 0) * 4) + 32'($urandom_range(3, 1));
      else a = BASE + 32'($urandom_range(63, 0) * 4);
      txn(d, 1'($urandom_range(1, 0)), a, $urandom, 4'($urandom_range(15, 0)), rd);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 1024; i++) begin
        mdl[d][i] = 32'h0000_0000;
        kn[d][i]  = 4'b0000;
      end
    test_reset();
    test_basic_read();
    test_wait_states();
    test_byte_lanes();
    test_back_to_back();
    test_errors();
    test_abort_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
